// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the fetch front end and Control_Unit.
// Contents:
//   - opcode constants for the supported base instruction classes
//   - fetch_state_t, the fetch FSM state encoding
//   - INSTR_BYTES, the instruction size used for sequential PC advance
//   - is_supported_op(), true for the opcodes the datapath implements
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StFlush
  } fetch_state_t;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end.
// Issues one instruction-memory request at a time from the PC, captures the
// returned word into an output register and offers it to decode with a
// valid/ready handshake. A branch/jump redirect overrides the PC and discards
// any response belonging to a fetch that was already in flight.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     request channel, addr is the current PC
//   imem_rsp_valid/data           one response per accepted request
//   instr_valid/ready             handshake towards decode
//   instr, instr_pc, opcode       registered word, its PC, and instr[6:0]
//   redirect_valid, redirect_pc   taken branch/jump, low two bits ignored
//   illegal                       unsupported opcode, qualified by instr_valid
//
// Optional feature: define FETCH_ILLEGAL_CHECK_EN to add the `illegal` port and
// its opcode check. Without the macro the port and logic are absent.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  // Instruction memory request
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  // Instruction memory response
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  // Decode side
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
`ifdef FETCH_ILLEGAL_CHECK_EN
  output logic            illegal,
`endif
  // Redirect
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            capture;

  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_next_seq;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  // Natural overflow gives the required modulo-2^XLEN wrap.
  assign pc_next_seq     = pc_q + XLEN'(INSTR_BYTES);

  // Redirect target is word aligned, so the low address bits are never used.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    capture       = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end

      StReq: begin
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
          // An accepted old-address request still owes us a response.
          state_d       = imem_req_ready ? StFlush : StReq;
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
          state_d       = imem_rsp_valid ? StReq : StFlush;
        end else if (imem_rsp_valid) begin
          capture       = 1'b1;
          instr_d       = imem_rsp_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_next_seq;
          state_d       = StHold;
        end
      end

      StHold: begin
        // A redirect alongside instr_ready still completes the decode handshake.
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end
      end

      StFlush: begin
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
        end
        // Leave only once the stale response has been swallowed, otherwise
        // it could be mistaken for the reply to the next request.
        if (imem_rsp_valid) begin
          state_d = StReq;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    req_valid_d = (state_d == StReq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign opcode         = instr_q[6:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (capture) begin
      illegal_d = ~is_supported_op(imem_rsp_data[6:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q & instr_valid_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the single-cycle/multi-cycle RISC-V datapath. It drives the instruction-memory request channel, tracks the program counter, and presents each fetched 32-bit instruction to the decode stage with a valid/ready handshake. Its `opcode` output is the producer side of the `OpCode` bus consumed by `Control_Unit`. It supports a branch/jump redirect that flushes any in-flight fetch.

## Interface

Parameters:
- `XLEN`, 32: PC and address width.
- `RESET_PC`, 0: PC value loaded at reset. Must be 4-byte aligned.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  fetch address, equal to the current PC.
- `imem_rsp_valid`  in  1  instruction word returned; one response per accepted request.
- `imem_rsp_data`  in  32  instruction word.
- `instr_valid`  out  1  decoded-side instruction valid.
- `instr_ready`  in  1  decode stage accepts the instruction.
- `instr`  out  32  registered instruction word.
- `instr_pc`  out  XLEN  PC of `instr`.
- `opcode`  out  7  `instr[6:0]`, feeds `Control_Unit.OpCode`.
- `redirect_valid`  in  1  taken branch or jump.
- `redirect_pc`  in  XLEN  new PC; bits [1:0] are ignored and forced to 0.
- `illegal`  out  1  unsupported opcode. Present only when the `FETCH_ILLEGAL_CHECK_EN` macro is defined.

## Operation

- FSM states: IDLE, REQ, WAIT, HOLD, FLUSH. Reset state is IDLE.
- **IDLE**: moves to REQ unconditionally on the next cycle.
- **REQ**: `imem_req_valid`=1 and `imem_req_addr`=`pc`.
  - On `imem_req_ready`, go to WAIT.
- **WAIT**: on `imem_rsp_valid`:
  - capture `imem_rsp_data` into `instr` and `pc` into `instr_pc`;
  - set `instr_valid`=1 and `pc` ← `pc`+4;
  - go to HOLD.
- **HOLD**: `instr`, `instr_pc` and `instr_valid` are held stable while `instr_ready`=0.
  - On `instr_ready`=1, clear `instr_valid` and go to REQ.
- **FLUSH**: waits for the single outstanding response, discards it, then goes to REQ.
- **Redirect** (`redirect_valid`=1 in any state except IDLE) has the highest priority:
  - `pc` ← {`redirect_pc`[XLEN-1:2], 2'b00}, and `instr_valid` clears next cycle.
  - From REQ with `imem_req_ready`=0: go to REQ with the new address.
  - From REQ with `imem_req_ready`=1 in the same cycle: the old-address request is already accepted, so go to FLUSH.
  - From WAIT with no response this cycle: go to FLUSH.
  - From WAIT with a simultaneous response: discard the response and go to REQ.
  - From HOLD: go to REQ. This applies even if `instr_ready`=1 in the same cycle (the decode handshake still completes).
  - From FLUSH: update `pc` and stay in FLUSH.
- PC arithmetic wraps modulo 2^XLEN, so 0xFFFF_FFFC+4 = 0.
- A `imem_rsp_valid` outside WAIT/FLUSH is ignored.

## Timing

- Reset values (while `rst_n`=0):
  - `pc`=`RESET_PC`, `imem_req_addr`=`RESET_PC`;
  - `imem_req_valid`=0, `instr_valid`=0;
  - `instr`=0, `instr_pc`=0, `opcode`=0, `illegal`=0.
- The first request is asserted 2 cycles after `rst_n` rises (IDLE, then REQ).
- Latency: `instr_valid` rises 1 cycle after the `imem_rsp_valid` cycle.
- Throughput: 3 cycles per instruction best case (zero-wait memory, `instr_ready` held at 1).
- `imem_req_valid` and `imem_req_addr` must stay stable until `imem_req_ready`, except on a redirect.
- An `rst_n` assertion mid-transaction forces IDLE immediately. A later late response is ignored because the FSM is not in WAIT or FLUSH.

## Configuration

- `FETCH_ILLEGAL_CHECK_EN`
  - Defined: `illegal` is registered with `instr`. It is 1 when `opcode` is not R-type (0110011), LOAD (0000011), STORE (0100011) or BRANCH (1100011), and is qualified by `instr_valid`. Behaviour is otherwise unchanged.
  - Undefined: the port and its logic are absent.

## Structure

- Shared package `riscv_pkg`, shared with `Control_Unit`, holds:
  - opcode constants `OP_RTYPE`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`;
  - the `fetch_state_t` enum;
  - the constant `INSTR_BYTES`=4.
- No sub-module. FSM, PC register and output register are all in one module.

## Test plan

- Reset with `RESET_PC`=0x100 and zero-wait memory returning 0x00A00093 -> `imem_req_addr`=0x100 two cycles after reset release; `instr`=0x00A00093, `instr_pc`=0x100, `opcode`=0010011; next request address is 0x104.
- `instr_ready` held at 0 for 5 cycles while `instr_valid`=1 -> `instr` and `instr_pc` stay stable and no new request is issued; the request to 0x104 appears 1 cycle after `instr_ready` rises.
- Redirect to 0x203 during WAIT; memory responds 2 cycles later -> that response is discarded, the next request address is 0x200, and no `instr_valid` is seen for the stale word.
- Redirect in HOLD together with `instr_ready`=1 -> the next request goes to the redirect PC, not PC+4.
- PC at 0xFFFFFFFC fetch -> the next request address is 0x00000000.
- With `FETCH_ILLEGAL_CHECK_EN` defined, fetch opcodes 0110011, 0000011, 0100011, 1100011 and 0000000 -> `illegal` is 0, 0, 0, 0 and 1 respectively.
